sccb_slave: RTL and testbench

Oversampled SCCB responder (target) for the OV5640 register protocol, answering on device ID 0x78/0x79 with 16-bit register addresses and 8-bit data. It sits behind the FPGA pins in the sensor-emulation and loopback test builds, facing the team's SCCB master driver. It converts bus transactions into single-cycle register-file write and read strobes. SDA is modelled as open-drain: the block only ever pulls SDA low, via an output enable.

---
 rtl/sccb_slave_if.sv | 28 ++
 rtl/sccb_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_slave_if.sv
// SCCB target bundle: the two bus pins (SCL in, SDA in plus pull-down
// enable) and the register-file strobe side.
//
// Register-side handshake: reg_wr and reg_rd are one-clk strobes with no
// back-pressure (an implied always-ready consumer). reg_addr and reg_wdata
// are stable while reg_wr is high. After reg_rd is high in clk N, the
// consumer must present reg_rdata during clk N+1; it is ignored otherwise.
interface sccb_slave_if;
   logic        sccb_clk;
   logic        sccb_sda_i;
   logic        sccb_sda_oe;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_rdata;
   logic        sccb_busy;

   modport slave (
      input  sccb_clk, sccb_sda_i, reg_rdata,
      output sccb_sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, sccb_busy
   );

   modport master (
      output sccb_clk, sccb_sda_i, reg_rdata,
      input  sccb_sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, sccb_busy
   );
endinterface

// File: rtl/sccb_slave.sv
// Oversampled SCCB target for the OV5640 register protocol: 7-bit device
// ID, 16-bit register pointer, 8-bit data, burst writes and burst reads.
// SCL/SDA are synchronized and edge-detected in the clk domain; SDA is
// only ever pulled low through sccb_sda_oe.
module sccb_slave #(
   parameter logic [6:0] DEV_ID = 7'h3C
) (
   input  logic       clk,
   input  logic       rst,
   sccb_slave_if.slave bus,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_DEV_ADDR = 4'd1,
      S_ACK_DEV  = 4'd2,
      S_REG_HI   = 4'd3,
      S_ACK_HI   = 4'd4,
      S_REG_LO   = 4'd5,
      S_ACK_LO   = 4'd6,
      S_WR_DATA  = 4'd7,
      S_ACK_WR   = 4'd8,
      S_RD_DATA  = 4'd9,
      S_RD_ACK   = 4'd10,
      S_IGNORE   = 4'd11
   } state_t;

   // synchronizer and edge-detect flops; reset to the idle bus level (high)
   logic scl_s1_q, scl_s2_q, scl_d_q;
   logic sda_s1_q, sda_s2_q, sda_d_q;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        oe_q, oe_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        reg_wr_q, reg_wr_d;
   logic        reg_rd_q, reg_rd_d;
   logic        rd_issue_q, rd_issue_d;
   logic        rd_load_q, rd_load_d;
   logic        busy_q, busy_d;
   logic        rw_q, rw_d;

   logic       scl_rise, scl_fall, start_det, stop_det, rx_done;
   logic [7:0] byte_v;

   // two-flop synchronizers plus one delay flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_d_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_d_q  <= 1'b1;
      end else begin
         scl_s1_q <= bus.sccb_clk;
         scl_s2_q <= scl_s1_q;
         scl_d_q  <= scl_s2_q;
         sda_s1_q <= bus.sccb_sda_i;
         sda_s2_q <= sda_s1_q;
         sda_d_q  <= sda_s2_q;
      end
   end

   // bus events; START/STOP need SCL high in both samples so that a
   // simultaneous SCL+SDA change reads as an ordinary data change
   always_comb begin
      scl_rise  = scl_s2_q & ~scl_d_q;
      scl_fall  = ~scl_s2_q & scl_d_q;
      start_det = scl_s2_q & scl_d_q & ~sda_s2_q & sda_d_q;
      stop_det  = scl_s2_q & scl_d_q & sda_s2_q & ~sda_d_q;
      byte_v    = {shift_q[6:0], sda_s2_q};
      rx_done   = scl_rise && (cnt_q == 3'd7);
   end

   // protocol FSM, bit counter, shifter, pointer and strobes
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      oe_d       = oe_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      reg_wr_d   = 1'b0;
      reg_rd_d   = 1'b0;
      rd_issue_d = 1'b0;
      rd_load_d  = reg_rd_q;
      busy_d     = busy_q;
      rw_d       = rw_q;

      // pointer advances on the clk after a write strobe
      if (reg_wr_q) addr_d = addr_q + 16'd1;
      // read request for the already-incremented pointer in a burst read
      if (rd_issue_q) reg_rd_d = 1'b1;
      // read data is captured exactly one clk after reg_rd
      if (rd_load_q) shift_d = bus.reg_rdata;

      if (start_det) begin
         state_d = S_DEV_ADDR;
         cnt_d   = 3'd0;
         busy_d  = 1'b1;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
         busy_d  = 1'b0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            S_DEV_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = byte_v;
                  cnt_d   = cnt_q + 3'd1;
               end
               if (rx_done) begin
                  case (state_q)
                     S_DEV_ADDR: begin
                        if (byte_v[7:1] == DEV_ID) begin
                           rw_d     = byte_v[0];
                           reg_rd_d = byte_v[0];
                           state_d  = S_ACK_DEV;
                        end else begin
                           state_d = S_IGNORE;
                        end
                     end
                     S_REG_HI: begin
                        addr_d[15:8] = byte_v;
                        state_d      = S_ACK_HI;
                     end
                     S_REG_LO: begin
                        addr_d[7:0] = byte_v;
                        state_d     = S_ACK_LO;
                     end
                     default: begin
                        wdata_d  = byte_v;
                        reg_wr_d = 1'b1;
                        state_d  = S_ACK_WR;
                     end
                  endcase
               end
            end

            S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
               // first falling edge pulls SDA low, second one releases it
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d  = 1'b0;
                     cnt_d = 3'd0;
                     case (state_q)
                        S_ACK_DEV: begin
                           if (rw_q) begin
                              state_d = S_RD_DATA;
                              oe_d    = ~shift_q[7];
                           end else begin
                              state_d = S_REG_HI;
                           end
                        end
                        S_ACK_HI: state_d = S_REG_LO;
                        default:  state_d = S_WR_DATA;
                     endcase
                  end
               end
            end

            S_RD_DATA: begin
               // bit 7 is already on the bus; count master samples and
               // present the next bit on each falling edge
               if (scl_rise) cnt_d = cnt_q + 3'd1;
               if (scl_fall) begin
                  if (cnt_q == 3'd0) begin
                     oe_d    = 1'b0;
                     state_d = S_RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end

            S_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     addr_d     = addr_q + 16'd1;
                     rd_issue_d = 1'b1;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
               if (scl_fall) begin
                  state_d = S_RD_DATA;
                  cnt_d   = 3'd0;
                  oe_d    = ~shift_q[7];
               end
            end

            default: begin
               // IDLE and IGNORE wait for START/STOP only
            end
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         oe_q       <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         reg_wr_q   <= 1'b0;
         reg_rd_q   <= 1'b0;
         rd_issue_q <= 1'b0;
         rd_load_q  <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         oe_q       <= oe_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         reg_wr_q   <= reg_wr_d;
         reg_rd_q   <= reg_rd_d;
         rd_issue_q <= rd_issue_d;
         rd_load_q  <= rd_load_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
      end
   end

   assign bus.sccb_sda_oe = oe_q;
   assign bus.reg_addr    = addr_q;
   assign bus.reg_wdata   = wdata_q;
   assign bus.reg_wr      = reg_wr_q;
   assign bus.reg_rd      = reg_rd_q;
   assign bus.sccb_busy   = busy_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-level SCCB master tasks, open-drain
// SDA resolution, a small register-file read responder and a strobe log.
module tb_sccb_slave;
   localparam int Q = 60;  // quarter SCL period in ns (SCL period = 24 clk)

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_RD_DATA = 4'd9;
   localparam logic [3:0] ST_IGNORE  = 4'd11;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] rdata_q = 8'hEE;
   logic [3:0] dbg_state;

   int total = 0;
   int bad = 0;
   int oe_cycles = 0;
   int wide_cnt = 0;
   logic wr_prev = 1'b0;
   logic rd_prev = 1'b0;

   logic [23:0] wr_log[$];
   logic [15:0] rd_log[$];
   logic [23:0] exp_q[$];
   logic [15:0] exp_rd_q[$];

   sccb_slave_if sif();

   assign sif.sccb_clk   = scl;
   assign sif.sccb_sda_i = sda_m & ~sif.sccb_sda_oe;
   assign sif.reg_rdata  = rdata_q;

   sccb_slave #(.DEV_ID(7'h3C)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (sif),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // register file read port: data valid only in the clk after reg_rd
   always @(posedge clk)
      rdata_q <= sif.reg_rd ? (sif.reg_addr[7:0] ^ 8'h5C) : 8'hEE;

   // strobe and pull-down monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (sif.reg_wr === 1'b1) wr_log.push_back({sif.reg_addr, sif.reg_wdata});
      if (sif.reg_rd === 1'b1) rd_log.push_back(sif.reg_addr);
      if (sif.sccb_sda_oe === 1'b1) oe_cycles++;
      if ((sif.reg_wr === 1'b1 && wr_prev) || (sif.reg_rd === 1'b1 && rd_prev)) wide_cnt++;
      wr_prev = (sif.reg_wr === 1'b1);
      rd_prev = (sif.reg_rd === 1'b1);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bus driver tasks ----------------
   task automatic drive_bit(input logic b);
      sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) drive_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; #Q; scl = 1'b1; #Q;
      ack = sif.sccb_sda_i;
      #Q; scl = 1'b0; #Q;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack_bit);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; #Q; scl = 1'b1; #Q;
         b[i] = sif.sccb_sda_i;
         #Q; scl = 1'b0; #Q;
      end
      sda_m = ack_bit; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      sda_m = 1'b1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
   endtask

   task automatic clear_logs();
      wr_log.delete();
      rd_log.delete();
      oe_cycles = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (sif.sccb_sda_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", sif.sccb_sda_oe); end
      total++; if (sif.reg_wr !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", sif.reg_wr); end
      total++; if (sif.reg_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", sif.reg_rd); end
      total++; if (sif.sccb_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sif.sccb_busy); end
      total++; if (sif.reg_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", sif.reg_addr); end
      total++; if (sif.reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", sif.reg_wdata); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_write();
      logic [7:0] seq [4];
      logic ack;
      seq = '{8'h78, 8'h30, 8'h08, 8'h82};
      clear_logs();
      bus_start();
      total++; if (sif.sccb_busy !== 1'b1) begin bad++; $display("FAIL write_busy_start: got %b want 1", sif.sccb_busy); end
      for (int i = 0; i < 4; i++) begin
         send_byte(seq[i], ack);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_ack byte %0d: got %b want 0", i, ack); end
      end
      bus_stop();
      exp_q = '{24'h300882};
      total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL write_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL write_entry %0d: got %h want %h", i, wr_log[i], exp_q[i]); end
      end
      total++; if (sif.reg_addr !== 16'h3009) begin bad++; $display("FAIL write_ptr: got %h want 3009", sif.reg_addr); end
      total++; if (rd_log.size() !== 0) begin bad++; $display("FAIL write_no_rd: got %0d want 0", rd_log.size()); end
      total++; if (sif.sccb_busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop: got %b want 0", sif.sccb_busy); end
   endtask

   task automatic test_read();
      logic [7:0] seq [3];
      logic [7:0] d;
      logic ack;
      seq = '{8'h78, 8'h30, 8'h0A};
      clear_logs();
      bus_start();
      for (int i = 0; i < 3; i++) begin
         send_byte(seq[i], ack);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_setup_ack byte %0d: got %b want 0", i, ack); end
      end
      bus_stop();
      // single read with NA
      bus_start();
      send_byte(8'h79, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_id_ack: got %b want 0", ack); end
      read_byte(d, 1'b1);
      total++; if (d !== 8'h56) begin bad++; $display("FAIL read_single: got %h want 56", d); end
      bus_stop();
      // burst read: pointer persisted, ACK then NA
      bus_start();
      send_byte(8'h79, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_burst_id_ack: got %b want 0", ack); end
      read_byte(d, 1'b0);
      total++; if (d !== 8'h56) begin bad++; $display("FAIL read_burst_b0: got %h want 56", d); end
      read_byte(d, 1'b1);
      total++; if (d !== 8'h57) begin bad++; $display("FAIL read_burst_b1: got %h want 57", d); end
      bus_stop();
      exp_rd_q = '{16'h300A, 16'h300A, 16'h300B};
      total++; if (rd_log.size() !== exp_rd_q.size()) begin bad++; $display("FAIL read_count: got %0d want %0d", rd_log.size(), exp_rd_q.size()); end
      else foreach (exp_rd_q[i]) begin
         total++; if (rd_log[i] !== exp_rd_q[i]) begin bad++; $display("FAIL read_addr %0d: got %h want %h", i, rd_log[i], exp_rd_q[i]); end
      end
      total++; if (wr_log.size() !== 0) begin bad++; $display("FAIL read_no_wr: got %0d want 0", wr_log.size()); end
      total++; if (sif.reg_addr !== 16'h300B) begin bad++; $display("FAIL read_ptr: got %h want 300b", sif.reg_addr); end
   endtask

   task automatic test_wrong_id();
      logic [7:0] seq [4];
      logic ack;
      seq = '{8'h42, 8'h30, 8'h08, 8'h11};
      clear_logs();
      bus_start();
      total++; if (sif.sccb_busy !== 1'b1) begin bad++; $display("FAIL wrongid_busy_start: got %b want 1", sif.sccb_busy); end
      for (int i = 0; i < 4; i++) begin
         send_byte(seq[i], ack);
         total++; if (ack !== 1'b1) begin bad++; $display("FAIL wrongid_nack byte %0d: got %b want 1", i, ack); end
         if (i == 0) begin
            total++; if (dbg_state !== ST_IGNORE) begin bad++; $display("FAIL wrongid_state: got %0d want %0d", dbg_state, ST_IGNORE); end
         end
      end
      total++; if (sif.sccb_busy !== 1'b1) begin bad++; $display("FAIL wrongid_busy_mid: got %b want 1", sif.sccb_busy); end
      bus_stop();
      total++; if (oe_cycles !== 0) begin bad++; $display("FAIL wrongid_oe: got %0d cycles want 0", oe_cycles); end
      total++; if (wr_log.size() + rd_log.size() !== 0) begin bad++; $display("FAIL wrongid_strobes: got %0d want 0", wr_log.size() + rd_log.size()); end
      total++; if (sif.sccb_busy !== 1'b0) begin bad++; $display("FAIL wrongid_busy_stop: got %b want 0", sif.sccb_busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [5];
      logic ack;
      clear_logs();
      // abort four bits into the low address byte
      bus_start();
      send_byte(8'h78, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL abort_id_ack: got %b want 0", ack); end
      send_byte(8'h12, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL abort_hi_ack: got %b want 0", ack); end
      send_bits(8'h34, 4);
      bus_stop();
      total++; if (wr_log.size() !== 0) begin bad++; $display("FAIL abort_no_wr: got %0d want 0", wr_log.size()); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_IDLE); end
      total++; if (sif.reg_addr !== 16'h120B) begin bad++; $display("FAIL abort_ptr: got %h want 120b", sif.reg_addr); end
      // burst write across the pointer wrap
      seq = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB};
      bus_start();
      for (int i = 0; i < 5; i++) begin
         send_byte(seq[i], ack);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL burst_ack byte %0d: got %b want 0", i, ack); end
      end
      bus_stop();
      exp_q = '{24'hFFFFAA, 24'h0000BB};
      total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL burst_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL burst_entry %0d: got %h want %h", i, wr_log[i], exp_q[i]); end
      end
      total++; if (sif.reg_addr !== 16'h0001) begin bad++; $display("FAIL burst_ptr: got %h want 0001", sif.reg_addr); end
      total++; if (wide_cnt !== 0) begin bad++; $display("FAIL strobe_width: got %0d wide strobes want 0", wide_cnt); end
   endtask

   task automatic test_reset_during_read();
      logic [7:0] seq [4];
      logic ack;
      // pointer 0x0010 holds 0x4C, so the first read bit pulls SDA low
      bus_start();
      send_byte(8'h78, ack);
      send_byte(8'h00, ack);
      send_byte(8'h10, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstrd_setup_ack: got %b want 0", ack); end
      bus_stop();
      bus_start();
      send_byte(8'h79, ack);
      total++; if (sif.sccb_sda_oe !== 1'b1) begin bad++; $display("FAIL rstrd_oe_before: got %b want 1", sif.sccb_sda_oe); end
      total++; if (dbg_state !== ST_RD_DATA) begin bad++; $display("FAIL rstrd_state_before: got %0d want %0d", dbg_state, ST_RD_DATA); end
      clear_logs();
      #2; rst = 1'b1;
      #1;
      total++; if (sif.sccb_sda_oe !== 1'b0) begin bad++; $display("FAIL rstrd_oe_async: got %b want 0", sif.sccb_sda_oe); end
      @(negedge clk);
      total++; if (sif.reg_addr !== 16'h0000) begin bad++; $display("FAIL rstrd_addr: got %h want 0000", sif.reg_addr); end
      total++; if (sif.reg_wdata !== 8'h00) begin bad++; $display("FAIL rstrd_wdata: got %h want 00", sif.reg_wdata); end
      total++; if (sif.sccb_busy !== 1'b0) begin bad++; $display("FAIL rstrd_busy: got %b want 0", sif.sccb_busy); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rstrd_state: got %0d want %0d", dbg_state, ST_IDLE); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (wr_log.size() + rd_log.size() !== 0) begin bad++; $display("FAIL rstrd_no_strobe: got %0d want 0", wr_log.size() + rd_log.size()); end
      // next write transaction completes normally
      seq = '{8'h78, 8'h00, 8'h20, 8'h99};
      bus_start();
      for (int i = 0; i < 4; i++) begin
         send_byte(seq[i], ack);
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstrd_wr_ack byte %0d: got %b want 0", i, ack); end
      end
      bus_stop();
      exp_q = '{24'h002099};
      total++; if (wr_log.size() !== exp_q.size()) begin bad++; $display("FAIL rstrd_wr_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
         total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL rstrd_wr_entry %0d: got %h want %h", i, wr_log[i], exp_q[i]); end
      end
      total++; if (sif.reg_addr !== 16'h0021) begin bad++; $display("FAIL rstrd_ptr: got %h want 0021", sif.reg_addr); end
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_write();
      test_read();
      test_wrong_id();
      test_back_to_back();
      test_reset_during_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
